// File: rtl/div32_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div32_seq : multi-cycle signed restoring divider, one quotient bit/cycle |
// | Optional macro DIV32_ZERO_FAST_EN: one-cycle early exit on a zero divisor|
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_q_q, sign_q_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rmo_q, rmo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shift_v, diff_v;
  logic               borrow, load;

  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_q_d = sign_q_q;
    quo_d    = quo_q;
    rmo_d    = rmo_q;
    dbz_d    = dbz_q;
    load     = 1'b0;

    // Magnitude of the most negative value is 2^31, which fits unsigned.
    abs_a   = RA[WIDTH-1] ? (~RA + 1'b1) : RA;
    abs_b   = RB[WIDTH-1] ? (~RB + 1'b1) : RB;
    shift_v = {rem_q, dvd_q[WIDTH-1]};
    diff_v  = shift_v - {1'b0, dvs_q};
    borrow  = diff_v[WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DIV32_ZERO_FAST_EN
          if (RB == '0) begin
            state_d = S_DONE;
            quo_d   = '0;
            rmo_d   = RA;
            dbz_d   = 1'b1;
          end else begin
            load = 1'b1;
          end
`else
          load = 1'b1;
`endif
        end
      end
      S_RUN: begin
        rem_d = borrow ? shift_v[WIDTH-1:0] : diff_v[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quo_d   = sign_q_q ? (~dvd_q + 1'b1) : dvd_q;
        rmo_d   = sign_a_q ? (~rem_q + 1'b1) : rem_q;
        dbz_d   = (dvs_q == '0);
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      state_d  = S_RUN;
      dvd_d    = abs_a;
      dvs_d    = abs_b;
      rem_d    = '0;
      cnt_d    = '0;
      sign_a_d = RA[WIDTH-1];
      sign_q_d = RA[WIDTH-1] ^ RB[WIDTH-1];
      dbz_d    = 1'b0;
    end

    busy_d = (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= S_IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      quo_q    <= '0;
      rmo_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_q_q <= sign_q_d;
      quo_q    <= quo_d;
      rmo_q    <= rmo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmo_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div32_seq.sv
`default_nettype none
// Self-checking bench for div32_seq: directed cases plus randomized operands
// compared against a truncating-division reference model.
module tb_div32_seq;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic [31:0] RA, RB;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  div32_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .start       (start),
    .RA          (RA),
    .RB          (RB),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: C-style truncating division; remainder follows the dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dbz);
    int sa, sb;
    sa = a;
    sb = b;
    dbz = 1'b0;
    if (sb == 0) begin
      dbz = 1'b1;
`ifdef DIV32_ZERO_FAST_EN
      q = 32'd0;
`else
      q = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
`endif
      r = a;
    end else if (a == 32'h8000_0000 && sb == -1) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV32_ZERO_FAST_EN
    return (b == 32'd0) ? 1 : 34;
`else
    return 34;
`endif
  endfunction

  // Drives one operation; lat = cycle index (1 = cycle after the accepting edge) when done rose.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dbz, output int lat, output int busy_bad);
    @(negedge clock);
    start = 1'b1;
    RA = a;
    RB = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    RA = $urandom;
    RB = $urandom;
    lat = -1;
    busy_bad = 0;
    q = '0;
    r = '0;
    dbz = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k;
        q = quotient;
        r = remainder;
        dbz = div_by_zero;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    start = 1'b0;
    RA = '0;
    RB = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h exp %h", quotient, 32'd0); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h exp %h", remainder, 32'd0); end
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, div_by_zero}); end
    clear_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic();
    logic [31:0] q, r;
    logic dbz;
    int lat, bb;
    run_div(32'd100, 32'd7, q, r, dbz, lat, bb);
    checks++; if (lat !== 34) begin errors++; $display("FAIL basic_latency got %0d exp 34", lat); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL basic_quotient got %h exp %h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL basic_remainder got %h exp %h", r, 32'd2); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b exp 0", dbz); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL basic_busy got %0d bad cycles exp 0", bb); end
  endtask

  task automatic test_signed_and_extremes();
    logic [31:0] ta [6] = '{32'hFFFF_FF9C, 32'd100,     32'hFFFF_FF9C, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] tb [6] = '{32'd7,         32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1,       32'h8000_0000};
    logic [31:0] tq [6] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14,      32'h8000_0000, 32'h8000_0000, 32'd0};
    logic [31:0] tr [6] = '{32'hFFFF_FFFE, 32'd2,       32'hFFFF_FFFE, 32'd0,       32'd0,       32'h7FFF_FFFF};
    logic [31:0] q, r;
    logic dbz;
    int lat, bb;
    for (int i = 0; i < 6; i++) begin
      run_div(ta[i], tb[i], q, r, dbz, lat, bb);
      checks++; if (q !== tq[i]) begin errors++; $display("FAIL table%0d_quotient got %h exp %h", i, q, tq[i]); end
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL table%0d_remainder got %h exp %h", i, r, tr[i]); end
      checks++; if (lat !== 34) begin errors++; $display("FAIL table%0d_latency got %0d exp 34", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r, eq;
    logic dbz;
    int lat, bb, el;
`ifdef DIV32_ZERO_FAST_EN
    eq = 32'd0;
    el = 1;
`else
    eq = 32'd1;
    el = 34;
`endif
    run_div(32'hFFFF_FFF9, 32'd0, q, r, dbz, lat, bb);
    checks++; if (q !== eq) begin errors++; $display("FAIL dz_quotient got %h exp %h", q, eq); end
    checks++; if (r !== 32'hFFFF_FFF9) begin errors++; $display("FAIL dz_remainder got %h exp %h", r, 32'hFFFF_FFF9); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b exp 1", dbz); end
    checks++; if (lat !== el) begin errors++; $display("FAIL dz_latency got %0d exp %0d", lat, el); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL dz_busy got %0d bad cycles exp 0", bb); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got %b exp 1", div_by_zero); end
    run_div(32'd9, 32'd2, q, r, dbz, lat, bb);
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL dz_cleared got %b exp 0", dbz); end
  endtask

  task automatic test_restart_ignored();
    int lat = -1;
    int ndone = 0;
    logic [31:0] q = '0;
    logic [31:0] r = '0;
    @(negedge clock);
    start = 1'b1;
    RA = 32'd100;
    RB = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; q = quotient; r = remainder; end
      end
      if (k == 4 || k == 19) begin
        start = 1'b1;
        RA = $urandom;
        RB = $urandom | 32'd1;
      end
    end
    start = 1'b0;
    checks++; if (lat !== 34) begin errors++; $display("FAIL restart_latency got %0d exp 34", lat); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL restart_quotient got %h exp %h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL restart_remainder got %h exp %h", r, 32'd2); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", ndone); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q, r;
    logic dbz;
    int lat, bb;
    int stray = 0;
    @(negedge clock);
    start = 1'b1;
    RA = 32'd1000;
    RB = 32'hFFFF_FFFD;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clock);
    clear_n = 1'b0;
    #1;
    checks++; if (quotient !== 32'd0) begin errors++; $display("FAIL midrst_quotient got %h exp %h", quotient, 32'd0); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL midrst_remainder got %h exp %h", remainder, 32'd0); end
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b exp 000", {busy, done, div_by_zero}); end
    @(negedge clock);
    clear_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done || busy) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_stray_activity got %0d exp 0", stray); end
    run_div(32'hFFFF_FF9C, 32'd7, q, r, dbz, lat, bb);
    checks++; if (q !== 32'hFFFF_FFF2) begin errors++; $display("FAIL midrst_after_quotient got %h exp %h", q, 32'hFFFF_FFF2); end
    checks++; if (r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL midrst_after_remainder got %h exp %h", r, 32'hFFFF_FFFE); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL midrst_after_latency got %0d exp 34", lat); end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = $urandom_range(0, 100) - 50;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er, recon;
    logic dbz, edbz;
    int lat, bb;
    for (int i = 0; i < 1000; i++) begin
      a = pick();
      b = pick();
      ref_div(a, b, eq, er, edbz);
      run_div(a, b, q, r, dbz, lat, bb);
      checks++; if (q !== eq) begin errors++; $display("FAIL rand_quotient a=%h b=%h got %h exp %h", a, b, q, eq); end
      checks++; if (r !== er) begin errors++; $display("FAIL rand_remainder a=%h b=%h got %h exp %h", a, b, r, er); end
      checks++; if (dbz !== edbz) begin errors++; $display("FAIL rand_dbz a=%h b=%h got %b exp %b", a, b, dbz, edbz); end
      checks++; if (lat !== exp_lat(b)) begin errors++; $display("FAIL rand_latency a=%h b=%h got %0d exp %0d", a, b, lat, exp_lat(b)); end
      if (b != 32'd0) begin
        recon = q * b + r;
        checks++; if (recon !== a) begin errors++; $display("FAIL rand_invariant a=%h b=%h got %h exp %h", a, b, recon, a); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_and_extremes();
    test_div_zero();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
